// File: rtl/win_detector_if.sv
// rtl/win_detector_if.sv - request/result bundle between board logic and the win detector
// master side (board/game control) drives start and the board vectors; slave side returns the result.
interface win_detector_if #(
   parameter int COLS = 7,
   parameter int ROWS = 6
);
   localparam int N = COLS * ROWS;

   logic           start;
   logic [N-1:0]   in_gameboard;
   logic [N-1:0]   in_players_cells;
   logic           busy;
   logic           done;
   logic [1:0]     out_winner;
   logic [N-1:0]   out_win_mask;

   modport master (
      output start,
      output in_gameboard,
      output in_players_cells,
      input  busy,
      input  done,
      input  out_winner,
      input  out_win_mask
   );

   modport slave (
      input  start,
      input  in_gameboard,
      input  in_players_cells,
      output busy,
      output done,
      output out_winner,
      output out_win_mask
   );
endinterface

// File: rtl/win_detector.sv
// rtl/win_detector.sv - sequential Connect4 four-in-a-row / draw detector, one anchor cell per clock
// Snapshots the board on start, scans anchors in index order and reports the first matching window.
module win_detector #(
   parameter int COLS = 7,
   parameter int ROWS = 6
) (
   input  logic              clk,
   input  logic              reset,
   win_detector_if.slave     bus
);
   localparam int N  = COLS * ROWS;
   localparam int IW = $clog2(N);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);

   localparam logic [IW-1:0] IDX_LAST     = IW'(N - 1);
   localparam logic [CW-1:0] COL_LAST     = CW'(COLS - 1);
   localparam logic [CW-1:0] COL_MAX_FWD  = CW'(COLS - 4);
   localparam logic [CW-1:0] COL_MIN_BACK = CW'(3);
   localparam logic [RW-1:0] ROW_MAX_UP   = RW'(ROWS - 4);

   // Window shapes anchored at cell 0; shifting by the anchor index places them on the board.
   localparam logic [N-1:0] P_ONE  = N'(1);
   localparam logic [N-1:0] PAT_H  = P_ONE | (P_ONE << 1) | (P_ONE << 2) | (P_ONE << 3);
   localparam logic [N-1:0] PAT_V  = P_ONE | (P_ONE << COLS) | (P_ONE << (2 * COLS))
                                     | (P_ONE << (3 * COLS));
   localparam logic [N-1:0] PAT_D1 = P_ONE | (P_ONE << (COLS + 1)) | (P_ONE << (2 * (COLS + 1)))
                                     | (P_ONE << (3 * (COLS + 1)));
   localparam logic [N-1:0] PAT_D2 = P_ONE | (P_ONE << (COLS - 1)) | (P_ONE << (2 * (COLS - 1)))
                                     | (P_ONE << (3 * (COLS - 1)));

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [IW-1:0]    r_idx;
   logic [CW-1:0]    r_col;
   logic [RW-1:0]    r_row;
   logic [N-1:0]     r_occ;
   logic [N-1:0]     r_own;
   logic             r_busy;
   logic             r_done;
   logic [1:0]       r_winner;
   logic [N-1:0]     r_mask;

   logic [N-1:0]     w_win [4];
   logic [3:0]       w_valid;
   logic [3:0]       w_match;
   logic [3:0]       w_owner;
   logic             w_hit;
   logic             w_hit_owner;
   logic [N-1:0]     w_hit_mask;

   always_comb begin
      w_win[0] = PAT_H  << r_idx;
      w_win[1] = PAT_V  << r_idx;
      w_win[2] = PAT_D1 << r_idx;
      w_win[3] = PAT_D2 << r_idx;

      w_valid[0] = (r_col <= COL_MAX_FWD);
      w_valid[1] = (r_row <= ROW_MAX_UP);
      w_valid[2] = (r_col <= COL_MAX_FWD) && (r_row <= ROW_MAX_UP);
      w_valid[3] = (r_col >= COL_MIN_BACK) && (r_row <= ROW_MAX_UP);

      w_match = '0;
      w_owner = '0;
      for (int d = 0; d < 4; d++) begin
         w_owner[d] = |(r_own & w_win[d]);
         w_match[d] = w_valid[d]
                      && ((r_occ & w_win[d]) == w_win[d])
                      && (((r_own & w_win[d]) == w_win[d]) || ((r_own & w_win[d]) == '0));
      end
   end

   // Fixed priority among the windows of one anchor: H, V, D1, D2.
   always_comb begin
      w_hit       = 1'b1;
      w_hit_owner = 1'b0;
      w_hit_mask  = '0;
      if (w_match[0]) begin
         w_hit_owner = w_owner[0];
         w_hit_mask  = w_win[0];
      end else if (w_match[1]) begin
         w_hit_owner = w_owner[1];
         w_hit_mask  = w_win[1];
      end else if (w_match[2]) begin
         w_hit_owner = w_owner[2];
         w_hit_mask  = w_win[2];
      end else if (w_match[3]) begin
         w_hit_owner = w_owner[3];
         w_hit_mask  = w_win[3];
      end else begin
         w_hit = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_col    <= '0;
         r_row    <= '0;
         r_occ    <= '0;
         r_own    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_winner <= 2'b00;
         r_mask   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_occ   <= bus.in_gameboard;
                  r_own   <= bus.in_players_cells;
                  r_idx   <= '0;
                  r_col   <= '0;
                  r_row   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (w_hit) begin
                  r_winner <= w_hit_owner ? 2'b10 : 2'b01;
                  r_mask   <= w_hit_mask;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end else if (r_idx == IDX_LAST) begin
                  r_winner <= (&r_occ) ? 2'b11 : 2'b00;
                  r_mask   <= '0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_idx <= r_idx + IW'(1);
                  if (r_col == COL_LAST) begin
                     r_col <= '0;
                     r_row <= r_row + RW'(1);
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.out_winner   = r_winner;
   assign bus.out_win_mask = r_mask;
endmodule

// File: tb/tb_win_detector.sv
// tb/tb_win_detector.sv - randomized self-checking bench for win_detector against a grid-walk model
module tb_win_detector;
   localparam int COLS = 7;
   localparam int ROWS = 6;
   localparam int N    = COLS * ROWS;

   logic clk;
   logic reset;
   int   n_total;
   int   n_bad;
   logic [1:0]   prev_w;
   logic [N-1:0] prev_m;

   win_detector_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

   win_detector #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Walks the grid by (row, col) and direction vectors; anchors in index order, H/V/D1/D2 per anchor.
   task automatic model(input logic [N-1:0] occ, input logic [N-1:0] own,
                        output logic [1:0] w, output logic [N-1:0] m, output int lat);
      int  dr [4];
      int  dc [4];
      bit  found;
      bit  ok;
      int  rr;
      int  cc;
      dr = '{0, 1, 1, 1};
      dc = '{1, 0, 1, -1};
      found = 1'b0;
      w   = (&occ) ? 2'b11 : 2'b00;
      m   = '0;
      lat = N;
      for (int a = 0; a < N; a++) begin
         for (int d = 0; d < 4; d++) begin
            if (!found) begin
               ok = 1'b1;
               for (int i = 0; i < 4; i++) begin
                  rr = a / COLS + i * dr[d];
                  cc = a % COLS + i * dc[d];
                  if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 1'b0;
                  else if (!occ[rr*COLS+cc] || (own[rr*COLS+cc] != own[a])) ok = 1'b0;
               end
               if (ok) begin
                  found = 1'b1;
                  w     = own[a] ? 2'b10 : 2'b01;
                  lat   = a + 1;
                  for (int i = 0; i < 4; i++)
                     m[(a / COLS + i * dr[d]) * COLS + (a % COLS + i * dc[d])] = 1'b1;
               end
            end
         end
      end
   endtask

   function automatic logic [N-1:0] rnd_vec();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[N-1:0];
   endfunction

   task automatic run_case(input string tag, input logic [N-1:0] occ, input logic [N-1:0] own,
                           input bit poke);
      logic [1:0]   ew;
      logic [N-1:0] em;
      int           elat;
      int           j;
      int           busy_cnt;
      int           extra_done;
      model(occ, own, ew, em, elat);
      @(negedge clk);
      bus.in_gameboard     = occ;
      bus.in_players_cells = own;
      bus.start            = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, "_hold_w"}, 64'(bus.out_winner), 64'(prev_w));
      chk({tag, "_hold_m"}, 64'(bus.out_win_mask), 64'(prev_m));
      j = 0;
      busy_cnt = 0;
      while (!bus.done && j < 200) begin
         if (bus.busy) busy_cnt++;
         bus.in_gameboard     = rnd_vec();
         bus.in_players_cells = rnd_vec();
         bus.start            = poke && (j == 0);
         @(negedge clk);
         j++;
      end
      bus.start = 1'b0;
      chk({tag, "_latency"}, 64'(j), 64'(elat));
      chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(elat));
      chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
      chk({tag, "_winner"}, 64'(bus.out_winner), 64'(ew));
      chk({tag, "_mask"}, 64'(bus.out_win_mask), 64'(em));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
      if (poke) begin
         extra_done = 0;
         for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.done) extra_done++;
         end
         chk({tag, "_no_queued_start"}, 64'(extra_done), 64'(0));
      end
      prev_w = ew;
      prev_m = em;
   endtask

   task automatic gravity_board(output logic [N-1:0] occ, output logic [N-1:0] own);
      int h [COLS];
      int moves;
      int c;
      occ = '0;
      own = '0;
      for (int i = 0; i < COLS; i++) h[i] = 0;
      moves = $urandom_range(4, 40);
      for (int mv = 0; mv < moves; mv++) begin
         c = $urandom_range(0, COLS - 1);
         if (h[c] < ROWS) begin
            occ[h[c]*COLS+c] = 1'b1;
            own[h[c]*COLS+c] = mv[0];
            h[c]++;
         end
      end
   endtask

   initial begin
      logic [N-1:0] occ;
      logic [N-1:0] own;
      int           dones;
      n_total = 0;
      n_bad   = 0;
      prev_w  = 2'b00;
      prev_m  = '0;
      reset   = 1'b1;
      bus.start            = 1'b0;
      bus.in_gameboard     = '0;
      bus.in_players_cells = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_done", 64'(bus.done), 64'(0));
      chk("rst_winner", 64'(bus.out_winner), 64'(0));
      chk("rst_mask", 64'(bus.out_win_mask), 64'(0));
      reset = 1'b0;

      run_case("empty", '0, '0, 1'b0);
      chk("empty_lit_w", 64'(bus.out_winner), 64'(2'b00));

      run_case("h_p1", N'(42'hF), '0, 1'b0);
      chk("h_p1_lit_mask", 64'(bus.out_win_mask), 64'h000000000F);
      chk("h_p1_lit_w", 64'(bus.out_winner), 64'(2'b01));

      occ = '0;
      occ[20] = 1'b1; occ[27] = 1'b1; occ[34] = 1'b1; occ[41] = 1'b1;
      run_case("v_p2", occ, occ, 1'b0);
      chk("v_p2_lit_w", 64'(bus.out_winner), 64'(2'b10));
      chk("v_p2_lit_mask", 64'(bus.out_win_mask), 64'(occ));

      occ = '1;
      own = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            own[r*COLS+c] = ((c + 2 * r) >> 1) & 1;
      run_case("draw", occ, own, 1'b0);
      chk("draw_lit_w", 64'(bus.out_winner), 64'(2'b11));

      occ = N'(42'hF);
      own = '0;
      occ[20] = 1'b1; occ[27] = 1'b1; occ[34] = 1'b1; occ[41] = 1'b1;
      own[20] = 1'b1; own[27] = 1'b1; own[34] = 1'b1; own[41] = 1'b1;
      run_case("both_poke", occ, own, 1'b1);
      chk("both_lit_mask", 64'(bus.out_win_mask), 64'hF);

      @(negedge clk);
      bus.in_gameboard     = '0;
      bus.in_players_cells = '0;
      bus.start            = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_busy", 64'(bus.busy), 64'(0));
      chk("abort_winner", 64'(bus.out_winner), 64'(0));
      chk("abort_mask", 64'(bus.out_win_mask), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      dones = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus.done || bus.busy) dones++;
      end
      chk("abort_no_done", 64'(dones), 64'(0));
      prev_w = 2'b00;
      prev_m = '0;
      run_case("after_abort", N'(42'hF), '0, 1'b0);

      for (int t = 0; t < 60; t++) begin
         case (t % 3)
            0: gravity_board(occ, own);
            1: begin
               occ = rnd_vec() | rnd_vec();
               own = rnd_vec();
            end
            default: begin
               occ = '1;
               own = rnd_vec();
            end
         endcase
         run_case($sformatf("rnd%0d", t), occ, own, t[2]);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
